pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
//  Multi-channel PWM decoder: measures period and active (duty) time of incoming PWM pins in clock cycles.
//  Receive-side counterpart of the 8-channel 16-bit PWM generator (active-low outputs, 2^16-cycle frame).
//  Sits on board inputs (servo/LED-driver loopback, external PWM sources); results go to the register bank.
// PARAMETERS
//  CHANNELS     8   number of independent capture channels
//  WIDTH        16  generator compare width; counters are CNT_W = WIDTH+1 bits (localparam) to hold a 2^WIDTH frame
//  ACTIVE_LOW   1   1: pin low = active (matches generator outputs); 0: pin high = active
//  SYNC_STAGES  2   input synchronizer depth (>=2)
// PORTS
//  clock     in   1               single system clock, rising edge
//  reset     in   1               asynchronous, active-high; clears all state
//  pwm_in    in   CHANNELS        raw asynchronous PWM pins
//  duty      out  CHANNELS*CNT_W  per-channel active cycles of last complete period; ch n at [n*CNT_W +: CNT_W]
//  period    out  CHANNELS*CNT_W  per-channel cycles of last complete period, same packing
//  valid     out  CHANNELS        1-cycle strobe per channel: duty/period of that channel just updated
//  timeout   out  CHANNELS        level: channel saw no active-going edge within 2^CNT_W-1 cycles
// BEHAVIOUR
//  Reset (async): duty=0, period=0, valid=0, timeout=0, synchronizers=inactive level, all FSMs IDLE.
//  Per channel: pwm_in -> SYNC_STAGES flops -> act = sync ^ ACTIVE_LOW (1 = active) -> act_q (1 flop).
//   rise = act & !act_q. Falling edges are not events; they only stop high counting.
//  FSM per channel: IDLE, MEASURE.
//   IDLE: counters held 0; on rise -> MEASURE, period_cnt<=1, high_cnt<=1, timeout<=0, no valid.
//   MEASURE, rise: duty<=high_cnt, period<=period_cnt, valid<=1 (next cycle only);
//    reload period_cnt<=1, high_cnt<=1; stay MEASURE.
//   MEASURE, no rise: period_cnt+=1; high_cnt+=act.
//   MEASURE, period_cnt==2^CNT_W-1 and no rise: timeout<=1, period<=all-ones,
//    duty<=all-ones if act else 0, valid<=1 once, -> IDLE.
//  Result: N = cycles from one active-going edge to the next; duty = active cycles within them.
//   Generator value v (0<v<2^WIDTH) loops back as period=2^WIDTH, duty=v exactly.
//  Latency: valid high SYNC_STAGES+2 rising clock edges after the first edge sampling the new pin level.
//  Simultaneous rise and saturation in the same cycle: rise wins (normal update, no timeout).
//  Constant level (v=0 or stuck pin): exactly one valid with timeout; then silent until next rise.
//  First rise after reset/timeout only arms; first valid comes one full period later.
//  1-cycle glitches that survive the synchronizer are counted as real edges (no filtering).
//  Reset mid-period: measurement discarded, no valid generated.
//  duty/period hold last value between strobes; channels fully independent, no cross-channel ordering.
// STRUCTURE
//  Shared package pwm_pkg: PWM_WIDTH=16, PWM_CHANNELS=8, ACTIVE_LOW default, capture FSM state enum
//   {CAP_IDLE, CAP_MEASURE}.
//  Sub-module pwm_capture_channel (sync, edge detect, FSM, counters, result regs) instantiated via
//   generate per channel; top only packs buses.
// TESTING
//  1 Loopback from generator, v0=16'h4000, others 0 -> ch0 valid every 65536 cycles,
//    period=17'h10000, duty=17'h04000.
//  2 Generator v=0 on ch1 -> after 2^17-1 cycles one valid, timeout[1]=1, duty=0, period=17'h1FFFF.
//    Pin held active -> duty=17'h1FFFF.
//  3 Driven pin: active 3 cycles, inactive 7, repeated -> period=10, duty=3;
//    valid exactly SYNC_STAGES+2 edges after pin edge.
//  4 Timed-out channel gets rise -> timeout clears, no valid for that edge;
//    next rise 20 cycles later -> period=20.
//  5 Assert reset mid-period (async, off clock edge) -> all outputs 0 immediately;
//    after release first rise yields no valid.
//  6 Rise coincident with period_cnt=2^17-1 -> normal valid, period=17'h1FFFF, timeout stays 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared PWM definitions: generator/capture defaults and the capture FSM state type.
package pwm_pkg;

  localparam int PWM_WIDTH       = 16;
  localparam int PWM_CHANNELS    = 8;
  localparam bit PWM_ACTIVE_LOW  = 1'b1;
  localparam int PWM_SYNC_STAGES = 2;

  typedef enum logic [0:0] {
    CAP_IDLE    = 1'b0,
    CAP_MEASURE = 1'b1
  } cap_state_e;

endpackage

// File: rtl/pwm_capture_channel.sv
// One PWM capture channel: synchronizer, active-going edge detect, period/duty
// counters, result registers and timeout on a stuck pin.
module pwm_capture_channel
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_WIDTH + 1,
  parameter bit ACTIVE_LOW  = PWM_ACTIVE_LOW,
  parameter int SYNC_STAGES = PWM_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pin_i,
  output logic [CNT_W-1:0] duty_o,
  output logic [CNT_W-1:0] period_o,
  output logic             valid_o,
  output logic             timeout_o
);

  localparam logic             IDLE_LVL = ACTIVE_LOW;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   act_q;
  logic                   act_dly_q;
  logic                   rise;

  cap_state_e       state_q, state_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // Synchronizer chain; bit 0 takes the raw pin, the MSB is the settled sample.
  // Resets to the inactive pin level so reset release never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) sync_q <= {SYNC_STAGES{IDLE_LVL}};
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Polarity-normalised level (1 = active) plus one delayed copy for edge detect.
  // Only the active-going edge matters; the falling edge just stops duty counting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q     <= 1'b0;
      act_dly_q <= 1'b0;
    end else begin
      act_q     <= sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;
      act_dly_q <= act_q;
    end
  end

  assign rise = act_q & ~act_dly_q;

  // State, counters and result registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= CAP_IDLE;
      pcnt_q    <= '0;
      hcnt_q    <= '0;
      duty_q    <= '0;
      period_q  <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      hcnt_q    <= hcnt_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next state: the first rise only arms, later rises close a period; a rise in the
  // saturation cycle still wins, so a period of exactly CNT_MAX is reported normally.
  always_comb begin
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    hcnt_d    = hcnt_q;
    duty_d    = duty_q;
    period_d  = period_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    case (state_q)
      CAP_IDLE: begin
        pcnt_d = '0;
        hcnt_d = '0;
        if (rise) begin
          state_d   = CAP_MEASURE;
          pcnt_d    = CNT_ONE;
          hcnt_d    = CNT_ONE;
          timeout_d = 1'b0;
        end
      end
      CAP_MEASURE: begin
        if (rise) begin
          duty_d   = hcnt_q;
          period_d = pcnt_q;
          valid_d  = 1'b1;
          pcnt_d   = CNT_ONE;
          hcnt_d   = CNT_ONE;
        end else if (pcnt_q == CNT_MAX) begin
          // Stuck pin: report the level it is stuck at, then wait for a fresh rise.
          timeout_d = 1'b1;
          period_d  = CNT_MAX;
          duty_d    = act_q ? CNT_MAX : '0;
          valid_d   = 1'b1;
          state_d   = CAP_IDLE;
          pcnt_d    = '0;
          hcnt_d    = '0;
        end else begin
          // hcnt never exceeds pcnt, so it cannot wrap before the saturation check.
          pcnt_d = pcnt_q + CNT_ONE;
          hcnt_d = hcnt_q + {{(CNT_W-1){1'b0}}, act_q};
        end
      end
      default: state_d = CAP_IDLE;
    endcase
  end

  assign duty_o    = duty_q;
  assign period_o  = period_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: rtl/pwm_capture.sv
// Multi-channel PWM decoder: per-channel period/duty measurement in clock cycles.
// Each channel is independent; this level only replicates and packs buses.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int  CHANNELS    = PWM_CHANNELS,
  parameter int  WIDTH       = PWM_WIDTH,
  parameter bit  ACTIVE_LOW  = PWM_ACTIVE_LOW,
  parameter int  SYNC_STAGES = PWM_SYNC_STAGES,
  localparam int CNT_W       = WIDTH + 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       pwm_in,
  output logic [CHANNELS*CNT_W-1:0] duty,
  output logic [CHANNELS*CNT_W-1:0] period,
  output logic [CHANNELS-1:0]       valid,
  output logic [CHANNELS-1:0]       timeout
);

  // One capture channel per pin; channel n packs at [n*CNT_W +: CNT_W].
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_capture_channel #(
      .CNT_W       (CNT_W),
      .ACTIVE_LOW  (ACTIVE_LOW),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clock     (clock),
      .reset     (reset),
      .pin_i     (pwm_in[g]),
      .duty_o    (duty[g*CNT_W +: CNT_W]),
      .period_o  (period[g*CNT_W +: CNT_W]),
      .valid_o   (valid[g]),
      .timeout_o (timeout[g])
    );
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture. A reduced WIDTH keeps frames and the
// saturation interval short (CNT_W=9: frame 256, saturation at 511).
module tb_pwm_capture;

  localparam int CH  = 4;
  localparam int W   = 8;
  localparam int CW  = W + 1;
  localparam int S   = 2;
  localparam int MAX = (1 << CW) - 1;

  logic               clock;
  logic               reset;
  logic [CH-1:0]      pwm_in;
  logic [CH*CW-1:0]   duty;
  logic [CH*CW-1:0]   period;
  logic [CH-1:0]      valid;
  logic [CH-1:0]      timeout;

  typedef struct {
    int          ch;
    logic [CW-1:0] duty;
    logic [CW-1:0] period;
    logic        to;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  pwm_capture #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .ACTIVE_LOW  (1'b1),
    .SYNC_STAGES (S)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .pwm_in  (pwm_in),
    .duty    (duty),
    .period  (period),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Active-low pins: active level drives 0.
  task automatic set_pin(input int c, input bit act);
    pwm_in[c] = act ? 1'b0 : 1'b1;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input int c, input int d, input int p, input bit to);
    exp_t e;
    e.ch = c; e.duty = CW'(d); e.period = CW'(p); e.to = to;
    sb_q.push_back(e);
  endtask

  // n periods of a active / i inactive cycles; each rise after the first closes a period.
  task automatic pattern(input int c, input int a, input int i, input int n);
    for (int r = 0; r < n; r++) begin
      if (r > 0) push(c, a, a + i, 1'b0);
      set_pin(c, 1'b1);
      cycles(a);
      set_pin(c, 1'b0);
      cycles(i);
    end
  endtask

  task automatic drain();
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pwm_in = '1;
    cycles(3);
    reset = 1'b0;
    cycles(2);
  endtask

  // Every valid strobe must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset) begin
      for (int c = 0; c < CH; c++) begin
        if (valid[c]) begin
          chk("valid_pending", 64'(sb_q.size() != 0), 64'd1);
          if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk("valid_ch", 64'(c), 64'(mon_e.ch));
            chk("duty", 64'(duty[c*CW +: CW]), 64'(mon_e.duty));
            chk("period", 64'(period[c*CW +: CW]), 64'(mon_e.period));
            chk("timeout_at_valid", 64'(timeout[c]), 64'(mon_e.to));
          end
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog checks=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b1;
    pwm_in = '1;
    #23;
    chk("rst_duty", 64'(duty), 64'd0);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    cycles(2);

    // Generator loopback on ch0: v=0x40 in a 256-cycle frame.
    pattern(0, 64, 192, 3);
    push(0, 64, 256, 1'b0);
    set_pin(0, 1'b1);
    cycles(10);
    drain();
    do_reset();

    // Stuck inactive after one rise on ch1 -> timeout, duty 0.
    set_pin(1, 1'b1);
    cycles(5);
    set_pin(1, 1'b0);
    push(1, 0, MAX, 1'b1);
    for (int k = 0; k < 600 && !timeout[1]; k++) cycles(1);
    chk("to_set_inactive", 64'(timeout[1]), 64'd1);
    cycles(40);
    chk("to_hold", 64'(timeout[1]), 64'd1);

    // Stuck active on ch2 -> timeout, duty all-ones.
    push(2, MAX, MAX, 1'b1);
    set_pin(2, 1'b1);
    for (int k = 0; k < 600 && !timeout[2]; k++) cycles(1);
    chk("to_set_active", 64'(timeout[2]), 64'd1);

    // Timed-out ch1 re-arms silently, next rise 20 cycles later reports period 20.
    set_pin(1, 1'b1);
    cycles(3);
    set_pin(1, 1'b0);
    cycles(17);
    chk("to_clr", 64'(timeout[1]), 64'd0);
    push(1, 3, 20, 1'b0);
    set_pin(1, 1'b1);
    cycles(3);
    set_pin(1, 1'b0);
    cycles(10);
    drain();
    do_reset();

    // Driven 3/7 pattern on ch2 with a latency check on the closing rise.
    pattern(2, 3, 7, 4);
    push(2, 3, 10, 1'b0);
    set_pin(2, 1'b1);
    for (int k = 1; k <= S + 2; k++) begin
      @(posedge clock);
      #1;
      if (k == S + 1) chk("lat_early", 64'(valid[2]), 64'd0);
      if (k == S + 2) chk("lat", 64'(valid[2]), 64'd1);
    end
    cycles(5);
    set_pin(2, 1'b0);
    cycles(5);
    drain();
    do_reset();

    // Rise exactly at saturation on ch3 is a normal period, then a real timeout.
    set_pin(3, 1'b1);
    cycles(4);
    set_pin(3, 1'b0);
    cycles(MAX - 4);
    push(3, 4, MAX, 1'b0);
    set_pin(3, 1'b1);
    cycles(3);
    set_pin(3, 1'b0);
    cycles(10);
    chk("sat_rise_no_to", 64'(timeout[3]), 64'd0);
    push(3, 0, MAX, 1'b1);
    for (int k = 0; k < 600 && !timeout[3]; k++) cycles(1);
    chk("to_after_sat", 64'(timeout[3]), 64'd1);
    cycles(3);
    drain();
    do_reset();

    // Async reset mid-period on ch0; measurement discarded, first rise re-arms.
    pattern(0, 3, 7, 2);
    push(0, 3, 10, 1'b0);
    set_pin(0, 1'b1);
    cycles(3);
    set_pin(0, 1'b0);
    cycles(4);
    drain();
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("mid_rst_duty", 64'(duty), 64'd0);
    chk("mid_rst_period", 64'(period), 64'd0);
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_timeout", 64'(timeout), 64'd0);
    cycles(2);
    reset = 1'b0;
    cycles(3);
    set_pin(0, 1'b1);
    cycles(3);
    set_pin(0, 1'b0);
    cycles(7);
    push(0, 3, 10, 1'b0);
    set_pin(0, 1'b1);
    cycles(3);
    set_pin(0, 1'b0);
    cycles(10);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
